// File: rtl/cpu6502_bus_if.sv
// cpu6502_bus_if
//   Bridges the cpu6502 core onto a req/ack memory bus. Every core cycle
//   becomes one handshaked transaction, and cpu_ready is held low until that
//   transaction completes. Read data is registered back to the core.
//
// Parameters
//   TIMEOUT   max REQ cycles without mem_ack before a forced completion (>=2)
//   ERR_DATA  read data returned to the core on a timed-out read
//
// Optional feature
//   CPU_BUS_TIMEOUT_EN  when defined, a watchdog ends a transaction after
//                       TIMEOUT unacknowledged REQ cycles and sets bus_err.
//                       When undefined, REQ waits for mem_ack forever, bus_err
//                       is tied low and err_clr is ignored.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   cpu_address/write/
//   cpu_data_o             core request, held stable while cpu_ready=0
//   cpu_data_i             registered read data to the core
//   cpu_ready              one-cycle pulse: the core advances on this edge
//   mem_req                registered transaction request
//   mem_we/addr/wdata      combinational pass-through of the core request
//   mem_rdata, mem_ack     slave read data and completion
//   err_clr, bus_err       clear input and sticky timeout flag
module cpu6502_bus_if #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [7:0]  ERR_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        err_clr,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       req_q, req_d;
  logic       rdy_q, rdy_d;
  logic [7:0] data_q, data_d;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic             timeout;
`endif

  assign mem_we     = cpu_write;
  assign mem_addr   = cpu_address;
  assign mem_wdata  = cpu_data_o;
  assign mem_req    = req_q;
  assign cpu_ready  = rdy_q;
  assign cpu_data_i = data_q;

  // Outputs are computed for the next state so they come straight from flops.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    rdy_d   = 1'b0;
    data_d  = data_q;
`ifdef CPU_BUS_TIMEOUT_EN
    wait_d  = wait_q;
    timeout = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
          if (!cpu_write) data_d = mem_rdata;
`ifdef CPU_BUS_TIMEOUT_EN
          wait_d  = '0;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          // Final allowed REQ cycle passed without ack: force completion.
          timeout = 1'b1;
          state_d = S_DONE;
          rdy_d   = 1'b1;
          wait_d  = '0;
          if (!cpu_write) data_d = ERR_DATA;
        end else begin
          req_d  = 1'b1;
          wait_d = wait_q + 1'b1;
`else
        end else begin
          req_d = 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
`ifdef CPU_BUS_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef CPU_BUS_TIMEOUT_EN
    // Set dominates clear when both happen in the same cycle.
    err_d = (err_q & ~err_clr) | timeout;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
    end
  end

`ifdef CPU_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = err_clr ^ (TIMEOUT < 2) ^ (ERR_DATA == 8'h00);
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu6502_bus_if.sv
// tb_cpu6502_bus_if
//   Directed bench for cpu6502_bus_if: zero-wait reads, waited write,
//   spurious acks, watchdog behaviour (or indefinite wait without it), and
//   asynchronous reset mid-transaction. Inputs change and outputs are sampled
//   on the falling clock edge.
module tb_cpu6502_bus_if;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_address;
  logic        cpu_write;
  logic [7:0]  cpu_data_o;
  logic [7:0]  cpu_data_i;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        err_clr;
  logic        bus_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  cpu6502_bus_if #(
    .TIMEOUT (64),
    .ERR_DATA(8'hFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_address(cpu_address),
    .cpu_write  (cpu_write),
    .cpu_data_o (cpu_data_o),
    .cpu_data_i (cpu_data_i),
    .cpu_ready  (cpu_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .err_clr    (err_clr),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    cpu_address = 16'h1234;
    cpu_write   = 1'b0;
    cpu_data_o  = 8'h00;
    mem_rdata   = 8'h00;
    mem_ack     = 1'b0;
    err_clr     = 1'b0;

    #3;
    check("rst_req",   32'(mem_req),    32'h0);
    check("rst_ready", 32'(cpu_ready),  32'h0);
    check("rst_data",  32'(cpu_data_i), 32'h00);
    check("rst_err",   32'(bus_err),    32'h0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("idle_req", 32'(mem_req), 32'h0);

    // Zero-wait read
    step();
    check("t1_req",  32'(mem_req),  32'h1);
    check("t1_rdy",  32'(cpu_ready), 32'h0);
    check("t1_addr", 32'(mem_addr), 32'h1234);
    check("t1_we",   32'(mem_we),   32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 8'hA5;
    step();
    check("t1_done_rdy",  32'(cpu_ready),  32'h1);
    check("t1_done_req",  32'(mem_req),    32'h0);
    check("t1_done_data", 32'(cpu_data_i), 32'hA5);

    // Ack held high through DONE is spurious and must not load data
    mem_rdata = 8'h5A;
    step();
    check("t5_req",  32'(mem_req),    32'h1);
    check("t5_rdy",  32'(cpu_ready),  32'h0);
    check("t5_data", 32'(cpu_data_i), 32'hA5);

    // Back-to-back zero-wait read: req pulses every two cycles
    mem_rdata = 8'hC3;
    step();
    check("t1b_rdy",  32'(cpu_ready),  32'h1);
    check("t1b_req",  32'(mem_req),    32'h0);
    check("t1b_data", 32'(cpu_data_i), 32'hC3);

    // Waited write, ack in the 5th REQ cycle
    cpu_address = 16'h0200;
    cpu_write   = 1'b1;
    cpu_data_o  = 8'h3C;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h77;
    step();
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("t2_req%0d", i),   32'(mem_req),   32'h1);
      check($sformatf("t2_rdy%0d", i),   32'(cpu_ready), 32'h0);
      check($sformatf("t2_we%0d", i),    32'(mem_we),    32'h1);
      check($sformatf("t2_wd%0d", i),    32'(mem_wdata), 32'h3C);
      check($sformatf("t2_addr%0d", i),  32'(mem_addr),  32'h0200);
      if (i == 5) mem_ack = 1'b1;
      step();
    end
    check("t2_done_rdy",  32'(cpu_ready),  32'h1);
    check("t2_done_req",  32'(mem_req),    32'h0);
    check("t2_done_data", 32'(cpu_data_i), 32'hC3);

    cpu_address = 16'h4000;
    cpu_write   = 1'b0;
    mem_ack     = 1'b0;
    step();

`ifdef CPU_BUS_TIMEOUT_EN
    // Read with no ack: req stays high exactly 64 cycles
    for (int i = 1; i <= 64; i++) begin
      check($sformatf("t3_req%0d", i), 32'(mem_req),   32'h1);
      check($sformatf("t3_rdy%0d", i), 32'(cpu_ready), 32'h0);
      step();
    end
    check("t3_done_rdy",  32'(cpu_ready),  32'h1);
    check("t3_done_req",  32'(mem_req),    32'h0);
    check("t3_done_data", 32'(cpu_data_i), 32'hFF);
    check("t3_err",       32'(bus_err),    32'h1);
    err_clr = 1'b1;
    step();
    check("t3_clr", 32'(bus_err), 32'h0);
    err_clr = 1'b0;

    // Ack in the 64th REQ cycle completes normally
    for (int i = 1; i <= 63; i++) begin
      check($sformatf("t4a_req%0d", i), 32'(mem_req), 32'h1);
      step();
    end
    check("t4a_req64", 32'(mem_req), 32'h1);
    mem_ack   = 1'b1;
    mem_rdata = 8'h42;
    step();
    check("t4a_rdy",  32'(cpu_ready),  32'h1);
    check("t4a_data", 32'(cpu_data_i), 32'h42);
    check("t4a_err",  32'(bus_err),    32'h0);
    mem_ack = 1'b0;
    step();

    // Timeout in the same cycle as err_clr: set wins
    for (int i = 1; i <= 63; i++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4b_rdy",  32'(cpu_ready),  32'h1);
    check("t4b_data", 32'(cpu_data_i), 32'hFF);
    check("t4b_err",  32'(bus_err),    32'h1);
    step();
`else
    // No watchdog: REQ holds indefinitely, err_clr has no effect
    err_clr = 1'b1;
    for (int i = 1; i <= 1000; i++) step();
    check("nto_req", 32'(mem_req),   32'h1);
    check("nto_rdy", 32'(cpu_ready), 32'h0);
    check("nto_err", 32'(bus_err),   32'h0);
    err_clr   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h42;
    step();
    check("nto_done_rdy",  32'(cpu_ready),  32'h1);
    check("nto_done_data", 32'(cpu_data_i), 32'h42);
    mem_ack = 1'b0;
    step();
`endif

    // Reset in the 3rd wait cycle of a read
    check("t6_req1", 32'(mem_req), 32'h1);
    step();
    step();
    check("t6_req3", 32'(mem_req), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_req",  32'(mem_req),    32'h0);
    check("t6_rst_rdy",  32'(cpu_ready),  32'h0);
    check("t6_rst_data", 32'(cpu_data_i), 32'h00);
    check("t6_rst_err",  32'(bus_err),    32'h0);
    step();
    step();
    // Late ack from the abandoned transaction lands in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 8'hE7;
    reset_n   = 1'b1;
    #1;
    check("t6_idle_req", 32'(mem_req), 32'h0);
    step();
    check("t6_req_req",  32'(mem_req),    32'h1);
    check("t6_req_rdy",  32'(cpu_ready),  32'h0);
    check("t6_req_data", 32'(cpu_data_i), 32'h00);
    step();
    check("t6_done_rdy",  32'(cpu_ready),  32'h1);
    check("t6_done_data", 32'(cpu_data_i), 32'hE7);
    mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
